// File: rtl/div_wrap_counter.sv
// div_wrap_counter: detects each 3->0 wrap of a 2-bit divider phase, pulses
// tick once per wrap, and after arm counts wraps up to a latched target.
// done is raised on the final wrap and held until ack.
module div_wrap_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       div_count,
  input  logic             arm,
  input  logic [CNT_W-1:0] target,
  input  logic             ack,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_prev;
  logic             r_tick;
  logic [CNT_W-1:0] r_tgt_q;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_tick_cnt_nxt;
  logic [CNT_W-1:0] w_tgt_nxt;

  // Only a 3->0 step is a wrap; 3->1, 2->0 and a held 0 are not.
  assign w_wrap    = (r_prev == 2'd3) && (div_count == 2'd0);
  assign w_cnt_inc = r_tick_cnt + CNT_W'(1);

  // Remember the previous phase and register the wrap as a one-cycle tick.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      r_prev <= 2'd0;
      r_tick <= 1'b0;
    end else begin
      r_prev <= div_count;
      r_tick <= w_wrap;
    end
  end

  // Next-state and datapath decode for the IDLE/RUN/DONE controller.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_tgt_nxt      = r_tgt_q;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_tgt_nxt      = target;
          w_tick_cnt_nxt = '0;
          // A zero target has nothing to count, so skip straight to DONE.
          w_state_nxt    = (target != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_wrap) begin
          w_tick_cnt_nxt = w_cnt_inc;
          // Exact compare is safe: tgt_q >= 1 here, so the count never wraps.
          if (w_cnt_inc == r_tgt_q) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched target, wrap count and registered status flags.
  // busy/done decode the next state so done lands with the final count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tgt_q    <= '0;
      r_tick_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt_q    <= w_tgt_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign tick     = r_tick;
  assign tick_cnt = r_tick_cnt;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_div_wrap_counter.sv
// Bench for div_wrap_counter: a cycle model predicts each cycle's outputs
// into a queue as stimulus is applied; the entry is popped after the edge.
module tb_div_wrap_counter;

  localparam int W = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk;
  logic         rst_n;
  logic [1:0]   div_count;
  logic         arm;
  logic [W-1:0] target;
  logic         ack;
  logic         tick;
  logic [W-1:0] tick_cnt;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic         tick;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int         m_mode;
  logic [1:0] m_prev;
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_tgt;

  logic [1:0] fd;  // free-running divider phase

  div_wrap_counter #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_count (div_count),
    .arm       (arm),
    .target    (target),
    .ack       (ack),
    .tick      (tick),
    .tick_cnt  (tick_cnt),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_prev = 2'd0;
    m_cnt  = '0;
    m_tgt  = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tick"}, {31'd0, tick}, 32'd0);
    check({tag, "_cnt"},  {24'd0, tick_cnt}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // One clock with reset active: outputs must stay at their reset values.
  task automatic cycle_rst(input logic [1:0] dc);
    div_count = dc;
    arm       = 1'b0;
    ack       = 1'b0;
    @(posedge clk);
    #1;
    check_zero("in_reset");
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic cycle(input logic [1:0] dc, input logic a, input logic [W-1:0] t, input logic k);
    exp_t e;
    exp_t got;
    logic m_wrap;
    div_count = dc;
    arm       = a;
    target    = t;
    ack       = k;
    m_wrap = (m_prev == 2'd3) && (dc == 2'd0);
    if (m_mode == M_IDLE) begin
      if (a) begin
        m_tgt  = t;
        m_cnt  = '0;
        m_mode = (t == '0) ? M_DONE : M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      if (m_wrap) begin
        m_cnt = m_cnt + 1'b1;
        if (m_cnt == m_tgt) m_mode = M_DONE;
      end
    end else begin
      if (k) m_mode = M_IDLE;
    end
    m_prev = dc;
    e.tick = m_wrap;
    e.cnt  = m_cnt;
    e.busy = (m_mode == M_RUN);
    e.done = (m_mode == M_DONE);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb_tick", {31'd0, tick}, {31'd0, got.tick});
    check("sb_cnt",  {24'd0, tick_cnt}, {24'd0, got.cnt});
    check("sb_busy", {31'd0, busy}, {31'd0, got.busy});
    check("sb_done", {31'd0, done}, {31'd0, got.done});
  endtask

  task automatic free(input logic a, input logic [W-1:0] t, input logic k);
    cycle(fd, a, t, k);
    fd = fd + 2'd1;
  endtask

  // Free-run until done, bounded by the worst-case run length.
  task automatic run_until_done(input logic [W-1:0] t, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      free(1'b0, t, 1'b0);
      n++;
    end
    check("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    int ticks;
    logic [1:0] nw_seq [7];

    rst_n     = 1'b0;
    div_count = 2'd0;
    arm       = 1'b0;
    target    = '0;
    ack       = 1'b0;
    fd        = 2'd0;
    model_reset();
    #1;
    check_zero("por");

    // Reset held while the divider cycles: everything stays 0.
    for (int i = 0; i < 8; i++) cycle_rst(2'(i));
    rst_n = 1'b1;
    model_reset();
    fd = 2'd1;
    free(1'b0, '0, 1'b0);  // 1
    free(1'b0, '0, 1'b0);  // 2
    free(1'b0, '0, 1'b0);  // 3
    check("pre_first_tick", {31'd0, tick}, 32'd0);
    free(1'b0, '0, 1'b0);  // 0: first wrap, tick one edge later
    check("first_tick", {31'd0, tick}, 32'd1);
    free(1'b0, '0, 1'b0);
    check("tick_one_cycle", {31'd0, tick}, 32'd0);

    // Basic run with target 3.
    free(1'b1, 8'd3, 1'b0);
    check("basic_busy_after_arm", {31'd0, busy}, 32'd1);
    run_until_done(8'd3, 4 * 3 + 4, n);
    check("basic_done_cnt", {24'd0, tick_cnt}, 32'd3);
    check("basic_busy_low", {31'd0, busy}, 32'd0);
    free(1'b0, 8'd3, 1'b0);
    check("done_held", {31'd0, done}, 32'd1);
    free(1'b0, 8'd3, 1'b1);
    check("ack_clears_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 6; i++) free(1'b0, 8'd3, 1'b0);
    check("cnt_held_in_idle", {24'd0, tick_cnt}, 32'd3);

    // Zero target: DONE right after the accepting edge, busy never set.
    free(1'b1, 8'd0, 1'b0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_cnt", {24'd0, tick_cnt}, 32'd0);
    free(1'b0, 8'd0, 1'b1);

    // Minimum done width: ack already high when DONE is entered.
    free(1'b1, 8'd0, 1'b1);
    check("min_done_on", {31'd0, done}, 32'd1);
    free(1'b0, 8'd0, 1'b1);
    check("min_done_off", {31'd0, done}, 32'd0);

    // Non-wrap transitions: only the final 3->0 ticks.
    nw_seq = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0};
    ticks = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(nw_seq[i], 1'b0, 8'd0, 1'b0);
      ticks += int'(tick);
    end
    check("nonwrap_tick_count", ticks, 32'd1);
    check("nonwrap_last_tick", {31'd0, tick}, 32'd1);

    // Arm coincident with a wrap: that wrap is not counted.
    cycle(2'd3, 1'b0, 8'd1, 1'b0);
    cycle(2'd0, 1'b1, 8'd1, 1'b0);
    check("arm_wrap_tick", {31'd0, tick}, 32'd1);
    check("arm_wrap_not_counted", {24'd0, tick_cnt}, 32'd0);
    check("arm_wrap_busy", {31'd0, busy}, 32'd1);
    fd = 2'd1;
    run_until_done(8'd1, 4 * 1 + 4, n);
    check("arm_wrap_final_cnt", {24'd0, tick_cnt}, 32'd1);

    // Ack coincident with a wrap in DONE: ticks, but count is frozen.
    cycle(2'd3, 1'b0, 8'd1, 1'b0);
    cycle(2'd0, 1'b0, 8'd1, 1'b1);
    check("ack_wrap_tick", {31'd0, tick}, 32'd1);
    check("ack_wrap_cnt", {24'd0, tick_cnt}, 32'd1);
    check("ack_wrap_done", {31'd0, done}, 32'd0);
    fd = 2'd1;

    // Arm mid-run with a new target is ignored.
    free(1'b1, 8'd2, 1'b0);
    n = 0;
    while (tick_cnt != 8'd1 && n < 12) begin
      free(1'b0, 8'd2, 1'b0);
      n++;
    end
    check("midrun_reach1", {24'd0, tick_cnt}, 32'd1);
    free(1'b1, 8'd9, 1'b0);
    run_until_done(8'd9, 12, n);
    check("midrun_final_cnt", {24'd0, tick_cnt}, 32'd2);
    free(1'b0, 8'd9, 1'b1);

    // Abort: reset mid-run forces outputs low without a clock edge.
    free(1'b1, 8'd5, 1'b0);
    n = 0;
    while (tick_cnt != 8'd2 && n < 16) begin
      free(1'b0, 8'd5, 1'b0);
      n++;
    end
    check("abort_reach2", {24'd0, tick_cnt}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_zero("abort_async");
    cycle_rst(fd);
    cycle_rst(fd + 2'd1);
    rst_n = 1'b1;
    model_reset();
    fd = 2'd0;
    free(1'b1, 8'd1, 1'b0);
    run_until_done(8'd1, 4 * 1 + 4, n);
    check("after_abort_cnt", {24'd0, tick_cnt}, 32'd1);
    free(1'b0, 8'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
